// File: rtl/bit_serializer.sv
// bit_serializer: accepts parallel words over a valid/ready handshake and
// shifts them out one bit per BIT_PERIOD clocks as a registered `value` bit
// with a one-cycle `update` strobe. Back-to-back words keep the strobe
// spacing unbroken.
//
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
// (XOR of all data bits) after the last data bit. That bit gets its own strobe.
// Without the macro no parity logic exists.
module bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_PERIOD = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  value,
    output logic                  update,
    output logic                  busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif

    // Counter widths stay at least one bit, so BIT_PERIOD=1 and NBITS=1 need no special handling.
    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    value_reg, value_next;
    logic                    update_reg, update_next;
`ifdef SERIALIZER_PARITY_EN
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    logic                    parity_reg, parity_next;
`endif

    // Bit-order selection: shifted word and the bit that leaves it next.
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    next_bit;
    logic                    first_bit;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted   = shift_reg << 1;
            assign next_bit  = shifted[DATA_WIDTH-1];
            assign first_bit = in_data[DATA_WIDTH-1];
        end else begin : g_lsb_first
            assign shifted   = shift_reg >> 1;
            assign next_bit  = shifted[0];
            assign first_bit = in_data[0];
        end
    endgenerate

    logic period_end;
    logic last_bit;
    logic accept;

    assign period_end = (cnt_reg == CNT_LAST);
    assign last_bit   = (idx_reg == IDX_LAST);

    // Ready depends only on state and counters. It is held low while reset is asserted.
    assign in_ready = reset && ((state_reg == IDLE) || (period_end && last_bit));
    assign accept   = in_valid && in_ready;

    assign value  = value_reg;
    assign update = update_reg;
    assign busy   = (state_reg == SHIFT);

    // State and datapath registers; an asserted reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            value_reg  <= 1'b0;
            update_reg <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            value_reg  <= value_next;
            update_reg <= update_next;
`ifdef SERIALIZER_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state logic. Accepting a word registers its first bit and strobe immediately.
    // The next bit is registered in the last cycle of each period, so it appears at the period boundary.
    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        value_next  = value_reg;
        update_next = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_next = parity_reg;
`endif

        if (accept) begin
            state_next  = SHIFT;
            shift_next  = in_data;
            idx_next    = '0;
            cnt_next    = '0;
            value_next  = first_bit;
            update_next = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity_next = ^in_data;
`endif
        end else if (state_reg == SHIFT) begin
            if (period_end) begin
                cnt_next = '0;
                if (last_bit) begin
                    state_next = IDLE;
                end else begin
                    idx_next    = idx_reg + 1'b1;
                    update_next = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    if (idx_reg == IDX_LAST_DATA) begin
                        value_next = parity_reg;
                    end else begin
                        value_next = next_bit;
                        shift_next = shifted;
                    end
`else
                    value_next = next_bit;
                    shift_next = shifted;
`endif
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer. Instance A is the default build
// (8 bits, period 4, MSB first). Instance B uses period 1 and LSB first.
// The drivers push the expected strobes (value and cycle) when a word is accepted.
// A monitor per instance pops those entries on every update strobe and compares them.
module tb_bit_serializer;

    typedef struct {
        logic v;
        int   c;
    } exp_t;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int P_A = 4;
    localparam int P_B = 1;
    // Cycle offset from an accept to the cycle in which in_ready is high again.
    localparam int RDY_A = NB * P_A;
    localparam int RDY_B = NB * P_B;

    logic       clk;
    logic       reset;
    logic [7:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       value_a, value_b;
    logic       update_a, update_b;
    logic       busy_a, busy_b;

    int cyc;
    int checks;
    int errors;
    exp_t q_a[$];
    exp_t q_b[$];

    bit_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(P_A), .MSB_FIRST(1'b1)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data_a),
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .value    (value_a),
        .update   (update_a),
        .busy     (busy_a)
    );

    bit_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(P_B), .MSB_FIRST(1'b0)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data_b),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .value    (value_b),
        .update   (update_b),
        .busy     (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor A: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (update_a === 1'b1) begin
            exp_t e;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL strobe_a: unexpected strobe value=%0b at cycle %0d", value_a, cyc);
            end else begin
                e = q_a.pop_front();
                if (value_a !== e.v || cyc != e.c) begin
                    errors++;
                    $display("FAIL strobe_a: got value=%0b cycle=%0d, expected value=%0b cycle=%0d",
                             value_a, cyc, e.v, e.c);
                end else begin
                    $display("ok   strobe_a: value=%0b cycle=%0d", value_a, cyc);
                end
            end
        end
    end

    // Monitor B: same checks for the LSB-first, period-1 instance.
    always @(negedge clk) begin
        if (update_b === 1'b1) begin
            exp_t e;
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL strobe_b: unexpected strobe value=%0b at cycle %0d", value_b, cyc);
            end else begin
                e = q_b.pop_front();
                if (value_b !== e.v || cyc != e.c) begin
                    errors++;
                    $display("FAIL strobe_b: got value=%0b cycle=%0d, expected value=%0b cycle=%0d",
                             value_b, cyc, e.v, e.c);
                end else begin
                    $display("ok   strobe_b: value=%0b cycle=%0d", value_b, cyc);
                end
            end
        end
    end

    // Present a word to A and wait (bounded) for the handshake. seq holds the hand-written
    // serial order with seq[7] as the first strobe, and par is the expected parity bit.
    // The task is called at a negedge and returns at the negedge after the accept edge.
    task automatic send_a(input logic [7:0] d, input logic [7:0] seq, input logic par,
                          output int acc);
        int n;
        exp_t e;
        in_data_a  = d;
        in_valid_a = 1'b1;
        n = 0;
        while (in_ready_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready_a !== 1'b1) begin
            check("handshake_a_timeout", 0, 1);
            in_valid_a = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        for (int k = 0; k < 8; k++) begin
            e.v = seq[7-k];
            e.c = acc + 1 + k * P_A;
            q_a.push_back(e);
        end
`ifdef SERIALIZER_PARITY_EN
        e.v = par;
        e.c = acc + 1 + 8 * P_A;
        q_a.push_back(e);
`else
        if (par) begin end
`endif
        @(negedge clk);
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [7:0] seq, input logic par,
                          output int acc);
        int n;
        exp_t e;
        in_data_b  = d;
        in_valid_b = 1'b1;
        n = 0;
        while (in_ready_b !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready_b !== 1'b1) begin
            check("handshake_b_timeout", 0, 1);
            in_valid_b = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        for (int k = 0; k < 8; k++) begin
            e.v = seq[7-k];
            e.c = acc + 1 + k * P_B;
            q_b.push_back(e);
        end
`ifdef SERIALIZER_PARITY_EN
        e.v = par;
        e.c = acc + 1 + 8 * P_B;
        q_b.push_back(e);
`else
        if (par) begin end
`endif
        @(negedge clk);
        in_valid_b = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        int acc1, acc2;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        in_data_a  = 8'h00;
        in_data_b  = 8'h00;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;

        // Reset held low for 3 cycles; outputs must be quiet and not ready.
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_update", update_a, 0);
        check("rst_value", value_a, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready_a, 1);
        check("idle_busy", busy_a, 0);
        check("idle_update", update_a, 0);
        check("idle_value", value_a, 0);
        check("idle_in_ready_b", in_ready_b, 1);
        repeat (20) @(negedge clk);   // Any strobe here is flagged by the monitors.

        // Single word 0xA5, MSB first: serial 1,0,1,0,0,1,0,1.
        send_a(8'hA5, 8'b1010_0101, 1'b0, acc1);
        for (int off = 1; off <= RDY_A + 2; off++) begin
            check($sformatf("a5_in_ready_off%0d", off), in_ready_a, (off >= RDY_A) ? 1 : 0);
            check($sformatf("a5_busy_off%0d", off), busy_a, (off <= RDY_A) ? 1 : 0);
            @(negedge clk);
        end
        drain(100);

        // Back-to-back 0xA5 then 0x3C with in_valid held high between them.
        send_a(8'hA5, 8'b1010_0101, 1'b0, acc1);
        send_a(8'h3C, 8'b0011_1100, 1'b0, acc2);
        check("b2b_accept_gap", acc2 - acc1, RDY_A);
        drain(100);

        // 0x07: parity bit is 1 when enabled.
        send_a(8'h07, 8'b0000_0111, 1'b1, acc1);
        drain(100);

        // LSB first, period 1: 0x01 gives 1,0,0,0,0,0,0,0; then 0x80 back to back.
        send_b(8'h01, 8'b1000_0000, 1'b1, acc1);
        send_b(8'h80, 8'b0000_0001, 1'b1, acc2);
        check("b_b2b_accept_gap", acc2 - acc1, RDY_B);
        drain(50);
        check("b_idle_ready", in_ready_b, 1);

        // Mid-word reset on 0xFF: outputs drop immediately and the partial word is lost.
        send_a(8'hFF, 8'b1111_1111, 1'b0, acc1);
        while (cyc < acc1 + 10) @(negedge clk);
        check("mid_pre_value", value_a, 1);
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        #1;
        check("mid_rst_update", update_a, 0);
        check("mid_rst_value", value_a, 0);
        check("mid_rst_in_ready", in_ready_a, 0);
        check("mid_rst_busy", busy_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_a, 1);
        check("post_rst_busy", busy_a, 0);
        repeat (40) @(negedge clk);   // Must produce no strobes.

        // A fresh word after reset is serialized normally.
        send_a(8'h3C, 8'b0011_1100, 1'b0, acc1);
        drain(100);

        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
